lsu_mem_arbiter: RTL and testbench

- Shares the single data-memory port between the two LSU lanes of the dual-issue pipeline.
- Serializes up to two accesses per bundle in program order: lane 0 is always older.
- Owns the `mem_stall_o` signal that freezes the LSU stage and everything upstream until both lanes' accesses are complete.
- Sits between the LSU stage registers and the dmem interface; load data goes to the writeback path.

---
 rtl/lsu_mem_arbiter_pkg.sv | 26 ++
 rtl/lsu_byte_align.sv | 33 +++
 rtl/lsu_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | Module  : lsu_mem_arbiter_pkg                                    |
// | Desc    : Shared size/state encodings for the LSU memory arbiter |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

package lsu_mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_align.sv
// +------------------------------------------------------------------+
// | Module  : lsu_byte_align                                         |
// | Desc    : Byte-enable generation and store-data lane shifting    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module lsu_byte_align
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_sh
);

  // Enables past byte 3 fall off the 4-bit vector, so straddling halves are truncated.
  always_comb begin
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
  end

  assign wdata_sh = wdata << {addr_lo, 3'b000};

endmodule

`default_nettype wire

// File: rtl/lsu_mem_arbiter.sv
// +------------------------------------------------------------------+
// | Module  : lsu_mem_arbiter                                        |
// | Desc    : Serialises the two LSU lanes onto one dmem port        |
// |           Optional: LSU_MISALIGN_TRAP_EN (misaligned-op trap)    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign0_o,
  output logic              misalign1_o,
`endif
  output logic              mem_stall_o
);

  arb_state_e r_state;
  logic       r_done0, r_done1;
  logic       r_ld0, r_ld1;
  logic       r_wait_lane;

  logic w_pend0, w_pend1, w_mis0, w_mis1;
  logic w_sel0, w_sel1, w_idle, w_issue;
  logic w_sel_we;
  logic [1:0]        w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic w_acc, w_store_done, w_load_go, w_rsp;
  logic w_done0_n, w_done1_n, w_ld0_n, w_ld1_n, w_all_done, w_to_release;

  assign w_pend0 = req0_i & ~r_done0;
  assign w_pend1 = req1_i & ~r_done1;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis0, r_mis1;
  logic w_mis0_n, w_mis1_n;
  assign w_mis0   = is_misaligned(size0_i, addr0_i[1:0]);
  assign w_mis1   = is_misaligned(size1_i, addr1_i[1:0]);
  assign w_mis0_n = r_mis0 | (w_idle & w_pend0 & w_mis0);
  assign w_mis1_n = r_mis1 | (w_idle & w_pend1 & w_mis1);
`else
  assign w_mis0 = 1'b0;
  assign w_mis1 = 1'b0;
`endif

  // A trapped lane never reaches the port, so the other lane may issue in the same cycle.
  assign w_sel0  = w_pend0 & ~w_mis0;
  assign w_sel1  = ~w_sel0 & w_pend1 & ~w_mis1;
  assign w_idle  = (r_state == ARB_IDLE);
  assign w_issue = w_idle & (w_sel0 | w_sel1);

  assign w_sel_we    = w_sel1 ? we1_i    : we0_i;
  assign w_sel_size  = w_sel1 ? size1_i  : size0_i;
  assign w_sel_addr  = w_sel1 ? addr1_i  : addr0_i;
  assign w_sel_wdata = w_sel1 ? wdata1_i : wdata0_i;

  lsu_byte_align #(.DATA_W(DATA_W)) u_align (
    .size     (w_sel_size),
    .addr_lo  (w_sel_addr[1:0]),
    .wdata    (w_sel_wdata),
    .be       (dmem_be_o),
    .wdata_sh (dmem_wdata_o)
  );

  assign dmem_req_o  = w_issue;
  assign dmem_we_o   = w_issue & w_sel_we;
  assign dmem_addr_o = {w_sel_addr[ADDR_W-1:2], 2'b00};
  assign mem_stall_o = (r_state != ARB_RELEASE) & (w_pend0 | w_pend1);

  assign w_acc        = w_issue & dmem_gnt_i;
  assign w_store_done = w_acc & w_sel_we;
  assign w_load_go    = w_acc & ~w_sel_we;
  assign w_rsp        = (r_state == ARB_WAIT) & dmem_rvalid_i;

  always_comb begin
    w_done0_n = r_done0;
    w_done1_n = r_done1;
    w_ld0_n   = r_ld0;
    w_ld1_n   = r_ld1;
    if (w_idle) begin
      if ((w_pend0 & w_mis0) | (w_store_done & w_sel0)) w_done0_n = 1'b1;
      if ((w_pend1 & w_mis1) | (w_store_done & w_sel1)) w_done1_n = 1'b1;
    end
    if (w_rsp) begin
      if (r_wait_lane) begin
        w_done1_n = 1'b1;
        w_ld1_n   = 1'b1;
      end else begin
        w_done0_n = 1'b1;
        w_ld0_n   = 1'b1;
      end
    end
  end

  // Finishing the last lane jumps straight to RELEASE so no idle bubble is added.
  assign w_all_done   = (w_done0_n | ~req0_i) & (w_done1_n | ~req1_i) & (req0_i | req1_i);
  assign w_to_release = (w_idle | w_rsp) & ~w_load_go & w_all_done;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ARB_IDLE;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_ld0       <= 1'b0;
      r_ld1       <= 1'b0;
      r_wait_lane <= 1'b0;
      rdata0_o    <= '0;
      rdata1_o    <= '0;
      rvalid0_o   <= 1'b0;
      rvalid1_o   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis0      <= 1'b0;
      r_mis1      <= 1'b0;
      misalign0_o <= 1'b0;
      misalign1_o <= 1'b0;
`endif
    end else begin
      rvalid0_o <= w_to_release & w_ld0_n;
      rvalid1_o <= w_to_release & w_ld1_n;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign0_o <= w_to_release & w_mis0_n;
      misalign1_o <= w_to_release & w_mis1_n;
`endif
      if (w_rsp && !r_wait_lane) rdata0_o <= dmem_rdata_i;
      if (w_rsp &&  r_wait_lane) rdata1_o <= dmem_rdata_i;

      if (r_state == ARB_RELEASE) begin
        r_done0 <= 1'b0;
        r_done1 <= 1'b0;
        r_ld0   <= 1'b0;
        r_ld1   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis0  <= 1'b0;
        r_mis1  <= 1'b0;
`endif
      end else begin
        r_done0 <= w_done0_n;
        r_done1 <= w_done1_n;
        r_ld0   <= w_ld0_n;
        r_ld1   <= w_ld1_n;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis0  <= w_mis0_n;
        r_mis1  <= w_mis1_n;
`endif
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_load_go) begin
            r_state     <= ARB_WAIT;
            r_wait_lane <= w_sel1;
          end else if (w_to_release) begin
            r_state <= ARB_RELEASE;
          end
        end
        ARB_WAIT: begin
          if (w_rsp) r_state <= w_to_release ? ARB_RELEASE : ARB_IDLE;
        end
        ARB_RELEASE: r_state <= ARB_IDLE;
        default:     r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_arbiter.sv
// +------------------------------------------------------------------+
// | Module  : tb_lsu_mem_arbiter                                     |
// | Desc    : Directed scoreboard bench for lsu_mem_arbiter          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        req0_i, req1_i, we0_i, we1_i;
  logic [1:0]  size0_i, size1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] rdata0_o, rdata1_o;
  logic        rvalid0_o, rvalid1_o, mem_stall_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign0_o, misalign1_o;
`endif

  always #5 clock_i = ~clock_i;

  lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .req0_i        (req0_i),
    .req1_i        (req1_i),
    .we0_i         (we0_i),
    .we1_i         (we1_i),
    .size0_i       (size0_i),
    .size1_i       (size1_i),
    .addr0_i       (addr0_i),
    .addr1_i       (addr1_i),
    .wdata0_i      (wdata0_i),
    .wdata1_i      (wdata1_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rdata0_o      (rdata0_o),
    .rdata1_o      (rdata1_o),
    .rvalid0_o     (rvalid0_o),
    .rvalid1_o     (rvalid1_o),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign0_o   (misalign0_o),
    .misalign1_o   (misalign1_o),
`endif
    .mem_stall_o   (mem_stall_o)
  );

  // Memory model: grant gated by gnt_en, load data returned one cycle after grant.
  logic        gnt_en, rv_en, late_rv;
  logic [31:0] late_data;
  logic        rsp_pend;
  logic [31:0] rsp_data;
  logic [31:0] mem [0:255];

  assign dmem_gnt_i    = dmem_req_o & gnt_en;
  assign dmem_rvalid_i = (rsp_pend & rv_en) | late_rv;
  assign dmem_rdata_i  = late_rv ? late_data : rsp_data;

  always @(posedge clock_i) begin
    rsp_pend <= 1'b0;
    if (dmem_req_o && dmem_gnt_i) begin
      if (dmem_we_o) begin
        for (int i = 0; i < 4; i++)
          if (dmem_be_o[i]) mem[dmem_addr_o[9:2]][8*i +: 8] <= dmem_wdata_o[8*i +: 8];
      end else begin
        rsp_pend <= 1'b1;
        rsp_data <= mem[dmem_addr_o[9:2]];
      end
    end
  end

  typedef struct {
    logic        rv0;
    logic        rv1;
    logic        mis0;
    logic [31:0] d0;
    logic [31:0] d1;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic req, input logic we,
                          input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    if (lane == 0) begin
      req0_i = req; we0_i = we; size0_i = size; addr0_i = addr; wdata0_i = wdata;
    end else begin
      req1_i = req; we1_i = we; size1_i = size; addr1_i = addr; wdata1_i = wdata;
    end
  endtask

  task automatic push(input logic rv0, input logic rv1, input logic mis0,
                      input logic [31:0] d0, input logic [31:0] d1, input int stalls);
    exp_t e;
    e.rv0 = rv0; e.rv1 = rv1; e.mis0 = mis0; e.d0 = d0; e.d1 = d1; e.stalls = stalls;
    sb.push_back(e);
  endtask

  // Counts remaining stall cycles, then checks the RELEASE cycle and the cycle after it.
  task automatic finish_bundle(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 0;
    while (mem_stall_o === 1'b1 && n < 40) begin
      n++;
      @(negedge clock_i); #1;
    end
    check({tag, " stall_cycles"}, n, e.stalls);
    check({tag, " rvalid0"}, {31'b0, rvalid0_o}, {31'b0, e.rv0});
    check({tag, " rvalid1"}, {31'b0, rvalid1_o}, {31'b0, e.rv1});
    if (e.rv0) check({tag, " rdata0"}, rdata0_o, e.d0);
    if (e.rv1) check({tag, " rdata1"}, rdata1_o, e.d1);
`ifdef LSU_MISALIGN_TRAP_EN
    check({tag, " misalign0"}, {31'b0, misalign0_o}, {31'b0, e.mis0});
`endif
    req0_i = 1'b0;
    req1_i = 1'b0;
    @(negedge clock_i); #1;
    check({tag, " post_rvalid0"}, {31'b0, rvalid0_o}, 32'd0);
    check({tag, " post_rvalid1"}, {31'b0, rvalid1_o}, 32'd0);
    check({tag, " post_stall"}, {31'b0, mem_stall_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b1;
    gnt_en = 1'b1; rv_en = 1'b1; late_rv = 1'b0; late_data = 32'd0;
    set_lane(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_lane(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    #2 reset_n_i = 1'b0;
    @(posedge clock_i); @(negedge clock_i); #1;
    check("reset stall",   {31'b0, mem_stall_o}, 32'd0);
    check("reset dmem_req", {31'b0, dmem_req_o}, 32'd0);
    check("reset rvalid0", {31'b0, rvalid0_o}, 32'd0);
    check("reset rvalid1", {31'b0, rvalid1_o}, 32'd0);
    check("reset rdata0",  rdata0_o, 32'd0);
    check("reset rdata1",  rdata1_o, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);

    // Single word store: one stall cycle.
    set_lane(0, 1'b1, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
    push(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1);
    #1;
    check("st_word req",   {31'b0, dmem_req_o}, 32'd1);
    check("st_word we",    {31'b0, dmem_we_o}, 32'd1);
    check("st_word addr",  dmem_addr_o, 32'h100);
    check("st_word be",    {28'b0, dmem_be_o}, 32'hF);
    check("st_word wdata", dmem_wdata_o, 32'hDEADBEEF);
    finish_bundle("st_word");

    // Single lane 0 load: two stall cycles.
    set_lane(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    push(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0, 2);
    #1;
    check("ld0 we", {31'b0, dmem_we_o}, 32'd0);
    finish_bundle("ld0");

    // Lane 0 store then lane 1 load to the same word: 1 + 2 stall cycles.
    set_lane(0, 1'b1, 1'b1, 2'b10, 32'h200, 32'h11223344);
    set_lane(1, 1'b1, 1'b0, 2'b10, 32'h200, 32'd0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 32'h11223344, 2);
    #1;
    check("pair first_we",   {31'b0, dmem_we_o}, 32'd1);
    check("pair first_addr", dmem_addr_o, 32'h200);
    @(negedge clock_i); #1;
    check("pair second_req", {31'b0, dmem_req_o}, 32'd1);
    check("pair second_we",  {31'b0, dmem_we_o}, 32'd0);
    finish_bundle("pair");

    // Byte store at offset 3 lands in the top lane.
    set_lane(0, 1'b1, 1'b1, 2'b00, 32'h103, 32'h000000AB);
    push(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1);
    #1;
    check("st_byte be",    {28'b0, dmem_be_o}, 32'h8);
    check("st_byte wdata", dmem_wdata_o, 32'hAB000000);
    check("st_byte addr",  dmem_addr_o, 32'h100);
    finish_bundle("st_byte");

    set_lane(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 32'hABADBEEF, 2);
    #1;
    finish_bundle("ld1_merge");

    // Grant withheld for four cycles on a lane 1 load.
    gnt_en = 1'b0;
    set_lane(1, 1'b1, 1'b0, 2'b10, 32'h200, 32'd0);
    push(1'b0, 1'b1, 1'b0, 32'd0, 32'h11223344, 2);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("nognt req",   {31'b0, dmem_req_o}, 32'd1);
      check("nognt addr",  dmem_addr_o, 32'h200);
      check("nognt stall", {31'b0, mem_stall_o}, 32'd1);
      @(negedge clock_i); #1;
    end
    gnt_en = 1'b1;
    finish_bundle("nognt");

    // No requests: quiet.
    for (int i = 0; i < 2; i++) begin
      check("idle stall", {31'b0, mem_stall_o}, 32'd0);
      check("idle req",   {31'b0, dmem_req_o}, 32'd0);
      @(negedge clock_i); #1;
    end

    // Reset while waiting on a load response, then a stray rvalid.
    rv_en = 1'b0;
    set_lane(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    @(negedge clock_i); #1;
    check("rst wait_stall", {31'b0, mem_stall_o}, 32'd1);
    reset_n_i = 1'b0;
    req0_i = 1'b0;
    #1;
    check("rst dmem_req", {31'b0, dmem_req_o}, 32'd0);
    check("rst stall",    {31'b0, mem_stall_o}, 32'd0);
    check("rst rdata0",   rdata0_o, 32'd0);
    check("rst rdata1",   rdata1_o, 32'd0);
    check("rst rvalid0",  {31'b0, rvalid0_o}, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    rv_en = 1'b1;
    late_rv = 1'b1;
    late_data = 32'h55AA55AA;
    @(negedge clock_i);
    late_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("late rvalid0", {31'b0, rvalid0_o}, 32'd0);
      check("late rvalid1", {31'b0, rvalid1_o}, 32'd0);
      check("late rdata0",  rdata0_o, 32'd0);
      @(negedge clock_i);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word load is trapped without touching memory.
    set_lane(0, 1'b1, 1'b0, 2'b10, 32'h102, 32'd0);
    push(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1);
    #1;
    check("mis req", {31'b0, dmem_req_o}, 32'd0);
    finish_bundle("mis");
`else
    // Half store straddling the word: upper byte silently dropped.
    set_lane(0, 1'b1, 1'b1, 2'b01, 32'h103, 32'h00001234);
    push(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1);
    #1;
    check("st_half be",    {28'b0, dmem_be_o}, 32'h8);
    check("st_half wdata", dmem_wdata_o, 32'h34000000);
    finish_bundle("st_half");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
